// File: rtl/maj_cone_pkg.sv
// Shared types and helpers for the majority-cone pipeline: stage operator
// encoding, pipeline latency function and the output beat counter width.
package maj_cone_pkg;

  typedef enum logic {
    MODE_MAJ  = 1'b0,
    MODE_OA21 = 1'b1
  } stage_mode_e;

  localparam int COUNT_W = 16;

  // Number of register slots, one per group of reg_every stages (last group may be short).
  function automatic int pipe_latency(input int depth, input int reg_every);
    return (depth + reg_every - 1) / reg_every;
  endfunction

endpackage

// File: rtl/maj_cone_stage.sv
// One combinational cone stage: bitwise majority or OR-AND of the running
// accumulator with the stage operands.
module maj_cone_stage
  import maj_cone_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic [WIDTH-1:0] acc_next
);

  always_comb begin
    acc_next = (acc & a) | (acc & b) | (a & b);
    if (stage_mode_e'(mode) == MODE_OA21) begin
      acc_next = (acc | a) & b;
    end
  end

endmodule

// File: rtl/maj_cone_pipe.sv
// DEPTH-stage majority/OR-AND cone with a register slot every REG_EVERY stages
// and valid/ready flow control. Optional parity: MAJ_CONE_PIPE_PARITY_EN.
module maj_cone_pipe
  import maj_cone_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 12,
  parameter int REG_EVERY = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_seed,
  input  logic [DEPTH*WIDTH-1:0] in_a,
  input  logic [DEPTH*WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0]       in_tap,
  input  logic [DEPTH-1:0]       stage_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [15:0]            beat_count
`ifdef MAJ_CONE_PIPE_PARITY_EN
  ,
  input  logic                   in_parity,
  output logic                   out_parity,
  output logic                   parity_err
`endif
);

  localparam int L  = pipe_latency(DEPTH, REG_EVERY);
  localparam int DW = DEPTH * WIDTH;

  logic [L-1:0]       valid_vec;
  logic [L-1:0]       load;
  logic [COUNT_W-1:0] count_reg;

  // A slot may load whenever some slot at or after it is empty, or the tail drains.
  genvar gi;
  generate
    for (gi = 0; gi < L; gi++) begin : g_load
      assign load[gi] = out_ready | ~(&valid_vec[L-1:gi]);
    end
  endgenerate

  generate
    for (gi = 0; gi < L; gi++) begin : g_slot
      localparam int LAST = ((gi + 1) * REG_EVERY < DEPTH) ? (gi + 1) * REG_EVERY - 1 : DEPTH - 1;

      logic             valid_in;
      logic             valid_reg;
      logic [WIDTH-1:0] acc_in;
      logic [WIDTH-1:0] acc_reg;
      logic [WIDTH-1:0] tap_in;
      logic [WIDTH-1:0] tap_reg;

      if (gi == 0) begin : g_src
        assign valid_in = in_valid;
        assign acc_in   = in_seed;
        assign tap_in   = in_tap;
      end else begin : g_src
        assign valid_in = g_slot[gi-1].valid_reg;
        assign acc_in   = g_slot[gi-1].acc_reg;
        assign tap_in   = g_slot[gi-1].tap_reg;
      end

      assign valid_vec[gi] = valid_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg <= 1'b0;
        end else if (load[gi]) begin
          valid_reg <= valid_in;
        end
      end

      always_ff @(posedge clk) begin
        if (load[gi]) begin
          acc_reg <= g_stage[LAST].acc_out;
          tap_reg <= tap_in;
        end
      end

      // Only operands of stages still ahead of this slot travel with the beat.
      if (gi < L - 1) begin : g_carry
        localparam int CN  = DEPTH - (gi + 1) * REG_EVERY;
        localparam int PCN = CN + REG_EVERY;

        logic [CN*WIDTH-1:0] a_reg;
        logic [CN*WIDTH-1:0] b_reg;
        logic [CN-1:0]       mode_reg;

        if (gi == 0) begin : g_fill
          always_ff @(posedge clk) begin
            if (load[gi]) begin
              a_reg    <= in_a[DW-1 -: CN*WIDTH];
              b_reg    <= in_b[DW-1 -: CN*WIDTH];
              mode_reg <= stage_mode[DEPTH-1 -: CN];
            end
          end
        end else begin : g_fill
          always_ff @(posedge clk) begin
            if (load[gi]) begin
              a_reg    <= g_slot[gi-1].g_carry.a_reg[PCN*WIDTH-1 -: CN*WIDTH];
              b_reg    <= g_slot[gi-1].g_carry.b_reg[PCN*WIDTH-1 -: CN*WIDTH];
              mode_reg <= g_slot[gi-1].g_carry.mode_reg[PCN-1 -: CN];
            end
          end
        end
      end
    end
  endgenerate

  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      localparam int SEG = gi / REG_EVERY;
      localparam int OFS = gi - SEG * REG_EVERY;

      logic [WIDTH-1:0] acc_in;
      logic [WIDTH-1:0] acc_out;
      logic [WIDTH-1:0] op_a;
      logic [WIDTH-1:0] op_b;
      logic             op_mode;

      if (OFS == 0) begin : g_acc
        assign acc_in = g_slot[SEG].acc_in;
      end else begin : g_acc
        assign acc_in = g_stage[gi-1].acc_out;
      end

      if (SEG == 0) begin : g_ops
        assign op_a    = in_a[gi*WIDTH +: WIDTH];
        assign op_b    = in_b[gi*WIDTH +: WIDTH];
        assign op_mode = stage_mode[gi];
      end else begin : g_ops
        assign op_a    = g_slot[SEG-1].g_carry.a_reg[OFS*WIDTH +: WIDTH];
        assign op_b    = g_slot[SEG-1].g_carry.b_reg[OFS*WIDTH +: WIDTH];
        assign op_mode = g_slot[SEG-1].g_carry.mode_reg[OFS];
      end

      maj_cone_stage #(
        .WIDTH(WIDTH)
      ) u_stage (
        .acc     (acc_in),
        .a       (op_a),
        .b       (op_b),
        .mode    (op_mode),
        .acc_next(acc_out)
      );
    end
  endgenerate

  assign in_ready  = ~rst & load[0];
  assign out_valid = ~rst & valid_vec[L-1];
  assign out_data  = out_valid ? ~(g_slot[L-1].acc_reg ^ g_slot[L-1].tap_reg) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (out_valid & out_ready) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign beat_count = count_reg;

`ifdef MAJ_CONE_PIPE_PARITY_EN
  logic parity_err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err_reg <= 1'b0;
    end else if (in_valid & in_ready & (in_parity != ^in_seed)) begin
      parity_err_reg <= 1'b1;
    end
  end

  assign out_parity = ^out_data;
  assign parity_err = parity_err_reg;
`endif

endmodule

// File: tb/tb_maj_cone_pipe.sv
// Self-checking bench for maj_cone_pipe at default parameters: directed vector
// table, randomized scoreboard run, reset flush, counter wrap, optional parity.
module tb_maj_cone_pipe;

  localparam int W  = 8;
  localparam int D  = 12;
  localparam int R  = 4;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_seed;
  logic [D*W-1:0] in_a;
  logic [D*W-1:0] in_b;
  logic [W-1:0]  in_tap;
  logic [D-1:0]  stage_mode;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [15:0]   beat_count;
  logic          in_parity;
  logic          out_parity;
  logic          parity_err;

  int n_checks = 0;
  int n_fail   = 0;

  maj_cone_pipe #(.WIDTH(W), .DEPTH(D), .REG_EVERY(R)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_seed   (in_seed),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tap    (in_tap),
    .stage_mode(stage_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .beat_count(beat_count)
`ifdef MAJ_CONE_PIPE_PARITY_EN
    ,
    .in_parity (in_parity),
    .out_parity(out_parity),
    .parity_err(parity_err)
`endif
  );

`ifndef MAJ_CONE_PIPE_PARITY_EN
  assign out_parity = 1'b0;
  assign parity_err = 1'b0;
`endif

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [W-1:0]   seed;
    logic [D*W-1:0] a;
    logic [D*W-1:0] b;
    logic [D-1:0]   mode;
    logic [W-1:0]   tap;
    logic [W-1:0]   exp;
  } vec_t;

  vec_t vt[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: each stage counts ones per bit (majority) or applies OR-then-AND.
  function automatic logic [W-1:0] ref_out(input logic [W-1:0] seed, input logic [D*W-1:0] a,
                                           input logic [D*W-1:0] b, input logic [D-1:0] mode,
                                           input logic [W-1:0] tap);
    int acc[W];
    logic [W-1:0] res;
    for (int k = 0; k < W; k++) acc[k] = int'(seed[k]);
    for (int s = 0; s < D; s++) begin
      for (int k = 0; k < W; k++) begin
        int x = acc[k];
        int y = int'(a[s*W+k]);
        int z = int'(b[s*W+k]);
        if (mode[s] == 1'b0) acc[k] = (x + y + z >= 2) ? 1 : 0;
        else                 acc[k] = ((x + y) > 0 ? 1 : 0) * z;
      end
    end
    for (int k = 0; k < W; k++) res[k] = (acc[k] == int'(tap[k])) ? 1'b1 : 1'b0;
    return res;
  endfunction

  function automatic logic [D*W-1:0] rep(input logic [W-1:0] x);
    return {D{x}};
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] seed, input logic [D*W-1:0] a,
                       input logic [D*W-1:0] b, input logic [D-1:0] mode, input logic [W-1:0] tap);
    in_valid   = v;
    in_seed    = seed;
    in_a       = a;
    in_b       = b;
    stage_mode = mode;
    in_tap     = tap;
    in_parity  = ^seed;
  endtask

  task automatic edge_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    logic [W-1:0]   r_seed, r_tap, hold_data;
    logic [D*W-1:0] r_a, r_b;
    logic [D-1:0]   r_mode;
    logic [W-1:0]   expq[$];
    logic [W-1:0]   e;
    logic           hold;
    int sent, outs, first_out, last_out, first_acc, last_acc, seen;

    vt[0] = '{seed: 8'h00, a: rep(8'hFF), b: rep(8'hFF), mode: 12'h000, tap: 8'h00, exp: 8'h00};
    vt[1] = '{seed: 8'h0F, a: rep(8'h00), b: rep(8'hF0), mode: 12'hFFF, tap: 8'hFF, exp: 8'h00};
    vt[2] = '{seed: 8'hAA, a: rep(8'h55), b: rep(8'hFF), mode: 12'h000, tap: 8'h0F, exp: 8'h0F};
    vt[3] = '{seed: 8'h3C, a: rep(8'h00), b: rep(8'hFF), mode: 12'hFFF, tap: 8'h3C, exp: 8'hFF};
    vt[4] = '{seed: 8'h00, a: rep(8'h0F), b: rep(8'hF0), mode: 12'h000, tap: 8'hA5, exp: 8'h5A};

    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, '0, '0, '0, '0, '0);
    repeat (2) edge_drive();
    settle();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_beat_count", beat_count, 0);
    check("rst_in_ready", in_ready, 0);
`ifdef MAJ_CONE_PIPE_PARITY_EN
    check("rst_parity_err", parity_err, 0);
`endif
    edge_drive();
    rst = 1'b0;
    edge_drive();
    settle();
    check("in_ready_after_rst", in_ready, 1);

    // Directed table: one beat each, exact latency of LAT cycles.
    for (int i = 0; i < 5; i++) begin
      edge_drive();
      drive(1'b1, vt[i].seed, vt[i].a, vt[i].b, vt[i].mode, vt[i].tap);
      settle();
      check($sformatf("vec%0d_in_ready", i), in_ready, 1);
      for (int c = 1; c <= LAT; c++) begin
        edge_drive();
        in_valid = 1'b0;
        settle();
        if (c < LAT) check($sformatf("vec%0d_early_valid_c%0d", i, c), out_valid, 0);
        else begin
          check($sformatf("vec%0d_out_valid", i), out_valid, 1);
          check($sformatf("vec%0d_out_data", i), out_data, vt[i].exp);
        end
      end
    end
    edge_drive();
    settle();
    check("beat_count_after_table", beat_count, 5);

    // 100 back-to-back beats with out_ready held high.
    sent = 0; outs = 0; first_out = -1; last_out = -1; first_acc = -1; last_acc = -1;
    for (int cyc = 0; cyc < 120; cyc++) begin
      edge_drive();
      drive(sent < 100, 8'h0F, rep(8'h00), rep(8'hF0), 12'hFFF, 8'hFF);
      settle();
      if (in_valid && in_ready) begin
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        sent++;
      end
      if (out_valid) begin
        check("b2b_out_data", out_data, 8'h00);
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        outs++;
      end
    end
    check("b2b_sent", sent, 100);
    check("b2b_accept_span", last_acc - first_acc, 99);
    check("b2b_outs", outs, 100);
    check("b2b_out_span", last_out - first_out, 99);
    check("b2b_first_latency", first_out - first_acc, LAT);
    check("b2b_beat_count", beat_count, 105);

    // Randomized stream with 50% backpressure against the reference model.
    sent = 0; outs = 0; hold = 1'b0; hold_data = '0;
    for (int cyc = 0; cyc < 4000 && sent < 300; cyc++) begin
      edge_drive();
      r_seed = W'($urandom); r_tap = W'($urandom); r_mode = D'($urandom);
      r_a = {$urandom, $urandom, $urandom};
      r_b = {$urandom, $urandom, $urandom};
      drive(($urandom_range(0, 9) < 7), r_seed, r_a, r_b, r_mode, r_tap);
      out_ready = $urandom_range(0, 1) == 1;
      settle();
      if (hold) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, hold_data);
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) check("rand_unexpected_output", out_data, 'x);
        else begin
          e = expq.pop_front();
          check($sformatf("rand_out%0d", outs), out_data, e);
        end
        outs++;
      end
      if (in_valid && in_ready) begin
        expq.push_back(ref_out(r_seed, r_a, r_b, r_mode, r_tap));
        sent++;
      end
      hold = out_valid && !out_ready;
      hold_data = out_data;
    end
    check("rand_sent", sent, 300);
    for (int cyc = 0; cyc < 20 && expq.size() > 0; cyc++) begin
      edge_drive();
      in_valid = 1'b0;
      out_ready = 1'b1;
      settle();
      if (out_valid) begin
        e = expq.pop_front();
        check($sformatf("drain_out%0d", outs), out_data, e);
        outs++;
      end
    end
    check("rand_outs", outs, 300);

    // Fill all slots under backpressure, then reset mid-flight.
    edge_drive();
    out_ready = 1'b0;
    in_valid = 1'b0;
    settle();
    for (int i = 0; i < LAT; i++) begin
      edge_drive();
      drive(1'b1, W'(i + 1), rep(8'h5A), rep(8'hC3), 12'h0F0, 8'h00);
      settle();
      check($sformatf("flush_fill_ready%0d", i), in_ready, 1);
    end
    edge_drive();
    in_valid = 1'b0;
    settle();
    check("full_stalled_in_ready", in_ready, 0);
    check("full_stalled_out_valid", out_valid, 1);
    edge_drive();
    rst = 1'b1;
    settle();
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_out_valid", out_valid, 0);
    edge_drive();
    rst = 1'b0;
    out_ready = 1'b1;
    settle();
    check("flush_beat_count", beat_count, 0);
    edge_drive();
    settle();
    check("flush_in_ready_after", in_ready, 1);
    seen = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      edge_drive();
      settle();
      if (out_valid) seen++;
    end
    check("flush_no_out_valid", seen, 0);

    // Counter wrap: 65537 accepted beats drains to beat_count == 1.
    sent = 0;
    for (int cyc = 0; cyc < 70000 && sent < 65537; cyc++) begin
      edge_drive();
      drive(1'b1, 8'h12, rep(8'h34), rep(8'h56), 12'hA5A, 8'h78);
      settle();
      if (in_valid && in_ready) sent++;
    end
    edge_drive();
    in_valid = 1'b0;
    repeat (LAT + 2) edge_drive();
    settle();
    check("wrap_sent", sent, 65537);
    check("wrap_beat_count", beat_count, 1);

`ifdef MAJ_CONE_PIPE_PARITY_EN
    edge_drive();
    drive(1'b1, 8'h01, rep(8'h00), rep(8'h00), 12'h000, 8'h00);
    in_parity = 1'b0;
    settle();
    check("par_clean_before", parity_err, 0);
    edge_drive();
    in_valid = 1'b0;
    in_parity = 1'b0;
    settle();
    check("par_err_set", parity_err, 1);
    repeat (4) edge_drive();
    settle();
    check("par_err_sticky", parity_err, 1);
    check("par_out_parity", out_parity, 1'b0);
    edge_drive();
    rst = 1'b1;
    edge_drive();
    rst = 1'b0;
    settle();
    check("par_err_cleared", parity_err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
